alu_imm_iq: RTL and testbench

//  ALU reg-imm issue queue; consumer end of the alu_imm dispatch-queue iq_enq_* handshake.

---
 rtl/alu_imm_iq.sv | 160 ++++++++++++++++
 tb/tb_alu_imm_iq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_imm_iq.sv
// ALU reg-imm issue queue: age-ordered, compressing, with source-A wakeup
// from the per-bank writeback bus and oldest-ready single issue.
package core_types_pkg;
  localparam int unsigned LOG_PR_COUNT       = 7;
  localparam int unsigned LOG_ROB_ENTRIES    = 6;
  localparam int unsigned PRF_BANK_COUNT     = 4;
  localparam int unsigned LOG_PRF_BANK_COUNT = 2;

  typedef struct packed {
    logic [3:0]                 op;
    logic [11:0]                imm12;
    logic [LOG_PR_COUNT-1:0]    a_pr;
    logic                       a_ready;
    logic                       a_is_zero;
    logic [LOG_PR_COUNT-1:0]    dest_pr;
    logic [LOG_ROB_ENTRIES-1:0] rob_index;
  } alu_imm_iq_entry_t;
endpackage

module alu_imm_iq
  import core_types_pkg::*;
#(
  parameter int unsigned ALU_IMM_IQ_ENTRIES = 8
) (
  input  logic                                           CLK,
  input  logic                                           nRST,
  input  logic                                           iq_enq_valid,
  input  logic [3:0]                                     iq_enq_op,
  input  logic [11:0]                                    iq_enq_imm12,
  input  logic [LOG_PR_COUNT-1:0]                        iq_enq_A_PR,
  input  logic                                           iq_enq_A_ready,
  input  logic                                           iq_enq_A_is_zero,
  input  logic [LOG_PR_COUNT-1:0]                        iq_enq_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]                     iq_enq_ROB_index,
  output logic                                           iq_enq_ready,
  input  logic [PRF_BANK_COUNT-1:0]                      WB_bus_valid_by_bank,
  input  logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0]     WB_bus_upper_PR_by_bank [PRF_BANK_COUNT],
  output logic                                           issue_valid,
  output logic [3:0]                                     issue_op,
  output logic [11:0]                                    issue_imm12,
  output logic                                           issue_A_forward,
  output logic                                           issue_A_is_zero,
  output logic [LOG_PR_COUNT-1:0]                        issue_A_PR,
  output logic [LOG_PR_COUNT-1:0]                        issue_dest_PR,
  output logic [LOG_ROB_ENTRIES-1:0]                     issue_ROB_index,
  input  logic                                           issue_ready
);

  localparam int unsigned N     = ALU_IMM_IQ_ENTRIES;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(N + 1);

  logic              valid_q [N];
  logic              valid_d [N];
  alu_imm_iq_entry_t ent_q   [N];
  alu_imm_iq_entry_t ent_d   [N];

  logic              wake    [N];
  logic              rdy     [N];
  alu_imm_iq_entry_t upd_ent [N];
  logic              sh_valid[N];
  alu_imm_iq_entry_t sh_ent  [N];
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  wr_slot;
  logic              enq_fire;
  alu_imm_iq_entry_t enq_ent;

  // Tag match of a physical register against its bank's writeback broadcast.
  function automatic logic pr_wakeup(input logic [LOG_PR_COUNT-1:0] pr);
    logic [LOG_PRF_BANK_COUNT-1:0] bank;
    bank = pr[LOG_PRF_BANK_COUNT-1:0];
    return WB_bus_valid_by_bank[bank] &
           (WB_bus_upper_PR_by_bank[bank] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
  endfunction

  always_comb begin
    iq_enq_ready    = ~valid_q[N-1];
    sel_found       = 1'b0;
    sel_idx         = '0;
    cnt             = '0;
    enq_fire        = iq_enq_valid & iq_enq_ready;
    enq_ent         = '0;
    for (int i = 0; i < N; i++) begin
      wake[i]       = pr_wakeup(ent_q[i].a_pr);
      rdy[i]        = valid_q[i] & (ent_q[i].a_ready | ent_q[i].a_is_zero | wake[i]);
      upd_ent[i]    = ent_q[i];
      upd_ent[i].a_ready = ent_q[i].a_ready | (valid_q[i] & wake[i]);
      cnt           = cnt + CNT_W'(valid_q[i]);
      valid_d[i]    = valid_q[i];
      ent_d[i]      = upd_ent[i];
      sh_valid[i]   = 1'b0;
      sh_ent[i]     = '0;
    end

    // Oldest ready entry wins.
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end

    issue_valid     = issue_ready & sel_found;
    issue_op        = ent_q[sel_idx].op;
    issue_imm12     = ent_q[sel_idx].imm12;
    issue_A_is_zero = ent_q[sel_idx].a_is_zero;
    issue_A_PR      = ent_q[sel_idx].a_pr;
    issue_dest_PR   = ent_q[sel_idx].dest_pr;
    issue_ROB_index = ent_q[sel_idx].rob_index;
    issue_A_forward = wake[sel_idx] & ~ent_q[sel_idx].a_ready & ~ent_q[sel_idx].a_is_zero;

    // Compression: entries above the issued slot move down one.
    for (int i = 0; i < N - 1; i++) begin
      sh_valid[i] = valid_q[i+1];
      sh_ent[i]   = upd_ent[i+1];
    end
    if (issue_valid) begin
      for (int i = 0; i < N; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          valid_d[i] = sh_valid[i];
          ent_d[i]   = sh_ent[i];
        end
      end
    end

    wr_slot           = cnt - CNT_W'(issue_valid);
    enq_ent.op        = iq_enq_op;
    enq_ent.imm12     = iq_enq_imm12;
    enq_ent.a_pr      = iq_enq_A_PR;
    enq_ent.a_ready   = iq_enq_A_ready | pr_wakeup(iq_enq_A_PR);
    enq_ent.a_is_zero = iq_enq_A_is_zero;
    enq_ent.dest_pr   = iq_enq_dest_PR;
    enq_ent.rob_index = iq_enq_ROB_index;
    if (enq_fire) begin
      for (int i = 0; i < N; i++) begin
        if (CNT_W'(i) == wr_slot) begin
          valid_d[i] = 1'b1;
          ent_d[i]   = enq_ent;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ent_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= valid_d[i];
        ent_q[i]   <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_imm_iq.sv
// Scoreboard bench for alu_imm_iq: stimulus pushes expected issues, a
// negedge monitor pops and compares every issued op.
module tb_alu_imm_iq;
  logic       CLK = 1'b0;
  logic       nRST;
  logic       iq_enq_valid;
  logic [3:0] iq_enq_op;
  logic [11:0] iq_enq_imm12;
  logic [6:0] iq_enq_A_PR;
  logic       iq_enq_A_ready;
  logic       iq_enq_A_is_zero;
  logic [6:0] iq_enq_dest_PR;
  logic [5:0] iq_enq_ROB_index;
  logic       iq_enq_ready;
  logic [3:0] wb_valid;
  logic [4:0] wb_upper [4];
  logic       issue_valid;
  logic [3:0] issue_op;
  logic [11:0] issue_imm12;
  logic       issue_A_forward;
  logic       issue_A_is_zero;
  logic [6:0] issue_A_PR;
  logic [6:0] issue_dest_PR;
  logic [5:0] issue_ROB_index;
  logic       issue_ready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] imm;
    logic        fwd;
    logic        zero;
    logic [6:0]  apr;
    logic [6:0]  dest;
    logic [5:0]  rob;
  } exp_t;
  exp_t exp_q[$];

  alu_imm_iq #(.ALU_IMM_IQ_ENTRIES(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iq_enq_valid(iq_enq_valid), .iq_enq_op(iq_enq_op), .iq_enq_imm12(iq_enq_imm12),
    .iq_enq_A_PR(iq_enq_A_PR), .iq_enq_A_ready(iq_enq_A_ready),
    .iq_enq_A_is_zero(iq_enq_A_is_zero), .iq_enq_dest_PR(iq_enq_dest_PR),
    .iq_enq_ROB_index(iq_enq_ROB_index), .iq_enq_ready(iq_enq_ready),
    .WB_bus_valid_by_bank(wb_valid), .WB_bus_upper_PR_by_bank(wb_upper),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_imm12(issue_imm12),
    .issue_A_forward(issue_A_forward), .issue_A_is_zero(issue_A_is_zero),
    .issue_A_PR(issue_A_PR), .issue_dest_PR(issue_dest_PR),
    .issue_ROB_index(issue_ROB_index), .issue_ready(issue_ready)
  );

  always #5 CLK = ~CLK;

  // Monitor: every issued op must match the head of the expected queue.
  always @(negedge CLK) begin
    if (nRST && issue_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got op=%h imm=%h rob=%h, required no issue",
                 issue_op, issue_imm12, issue_ROB_index);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (issue_op !== e.op || issue_imm12 !== e.imm || issue_A_forward !== e.fwd ||
            issue_A_is_zero !== e.zero || issue_A_PR !== e.apr ||
            issue_dest_PR !== e.dest || issue_ROB_index !== e.rob) begin
          n_err++;
          $display("FAIL issue_fields: got op=%h imm=%h fwd=%b zero=%b apr=%h dest=%h rob=%h, required op=%h imm=%h fwd=%b zero=%b apr=%h dest=%h rob=%h",
                   issue_op, issue_imm12, issue_A_forward, issue_A_is_zero, issue_A_PR,
                   issue_dest_PR, issue_ROB_index, e.op, e.imm, e.fwd, e.zero, e.apr,
                   e.dest, e.rob);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic enq(input logic [3:0] op, input logic [11:0] imm, input logic [6:0] apr,
                     input logic ardy, input logic azero, input logic [6:0] dest,
                     input logic [5:0] rob);
    iq_enq_op = op; iq_enq_imm12 = imm; iq_enq_A_PR = apr; iq_enq_A_ready = ardy;
    iq_enq_A_is_zero = azero; iq_enq_dest_PR = dest; iq_enq_ROB_index = rob;
    iq_enq_valid = 1'b1;
    step();
    iq_enq_valid = 1'b0;
  endtask

  task automatic expect_issue(input logic [3:0] op, input logic [11:0] imm, input logic fwd,
                              input logic zero, input logic [6:0] apr, input logic [6:0] dest,
                              input logic [5:0] rob);
    exp_t e;
    e.op = op; e.imm = imm; e.fwd = fwd; e.zero = zero; e.apr = apr; e.dest = dest; e.rob = rob;
    exp_q.push_back(e);
  endtask

  task automatic wake(input int bank, input logic [4:0] up);
    wb_valid[bank] = 1'b1;
    wb_upper[bank] = up;
  endtask

  task automatic clear_wb();
    wb_valid = '0;
    for (int b = 0; b < 4; b++) wb_upper[b] = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d ops still expected, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; issue_ready = 1'b1; iq_enq_valid = 1'b0;
    iq_enq_op = '0; iq_enq_imm12 = '0; iq_enq_A_PR = '0; iq_enq_A_ready = 1'b0;
    iq_enq_A_is_zero = 1'b0; iq_enq_dest_PR = '0; iq_enq_ROB_index = '0;
    clear_wb();
    step(); step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("reset_issue_valid", 32'(issue_valid), 0);
    chk("reset_enq_ready", 32'(iq_enq_ready), 1);

    // 1: three ready ops issue in enqueue order
    expect_issue(4'h1, 12'h001, 0, 0, 7'h01, 7'h11, 6'h01);
    expect_issue(4'h2, 12'h002, 0, 0, 7'h02, 7'h12, 6'h02);
    expect_issue(4'h3, 12'h003, 0, 0, 7'h03, 7'h13, 6'h03);
    enq(4'h1, 12'h001, 7'h01, 1, 0, 7'h11, 6'h01);
    @(negedge CLK); chk("t1_enq_ready_a", 32'(iq_enq_ready), 1);
    enq(4'h2, 12'h002, 7'h02, 1, 0, 7'h12, 6'h02);
    @(negedge CLK); chk("t1_enq_ready_b", 32'(iq_enq_ready), 1);
    enq(4'h3, 12'h003, 7'h03, 1, 0, 7'h13, 6'h03);
    @(negedge CLK); chk("t1_enq_ready_c", 32'(iq_enq_ready), 1);
    drain(5);

    // 2a: wakeup in the WB cycle forwards
    step();
    expect_issue(4'h7, 12'h025, 1, 0, 7'h25, 7'h40, 6'h07);
    enq(4'h7, 12'h025, 7'h25, 0, 0, 7'h40, 6'h07);
    @(negedge CLK); chk("t2_wait_no_issue", 32'(issue_valid), 0);
    step();
    wake(1, 5'h09);
    @(negedge CLK); chk("t2_wb_issue", 32'(issue_valid), 1);
    step();
    clear_wb();
    drain(5);

    // 2b: wakeup while stalled latches; later issue is not forwarded
    issue_ready = 1'b0;
    enq(4'h8, 12'h125, 7'h25, 0, 0, 7'h41, 6'h08);
    wake(1, 5'h09);
    step();
    clear_wb();
    @(negedge CLK); chk("t2b_stall_no_issue", 32'(issue_valid), 0);
    step();
    expect_issue(4'h8, 12'h125, 0, 0, 7'h25, 7'h41, 6'h08);
    issue_ready = 1'b1;
    drain(5);

    // 3: younger ready op bypasses older waiting op
    expect_issue(4'h9, 12'h0B0, 0, 0, 7'h05, 7'h51, 6'h11);
    enq(4'h3, 12'h0A0, 7'h11, 0, 0, 7'h50, 6'h10);
    enq(4'h9, 12'h0B0, 7'h05, 1, 0, 7'h51, 6'h11);
    drain(5);
    step(); step(); step();
    expect_issue(4'h3, 12'h0A0, 1, 0, 7'h11, 7'h50, 6'h10);
    wake(1, 5'h04);
    @(negedge CLK); chk("t3_x_wake_issue", 32'(issue_valid), 1);
    step();
    clear_wb();
    @(negedge CLK); chk("t3_empty", 32'(issue_valid), 0);

    // 4: fill, block, wake middle entry, refill into the top slot
    for (int i = 0; i < 8; i++)
      enq(4'h4, 12'(i), 7'(8'h40 + i), 0, 0, 7'(8'h20 + i), 6'(8'h20 + i));
    @(negedge CLK); chk("t4_full_ready", 32'(iq_enq_ready), 0);
    enq(4'hF, 12'hFFF, 7'h7F, 1, 0, 7'h7F, 6'h3F);
    @(negedge CLK);
    chk("t4_still_full", 32'(iq_enq_ready), 0);
    chk("t4_no_issue", 32'(issue_valid), 0);
    step();
    expect_issue(4'h4, 12'h003, 1, 0, 7'h43, 7'h23, 6'h23);
    wake(3, 5'h10);
    @(negedge CLK);
    chk("t4_wake3_issue", 32'(issue_valid), 1);
    chk("t4_full_issue_blocked", 32'(iq_enq_ready), 0);
    step();
    clear_wb();
    @(negedge CLK); chk("t4_slot_freed", 32'(iq_enq_ready), 1);
    enq(4'h5, 12'h050, 7'h50, 0, 0, 7'h30, 6'h30);
    @(negedge CLK); chk("t4_refull", 32'(iq_enq_ready), 0);
    expect_issue(4'h4, 12'h000, 1, 0, 7'h40, 7'h20, 6'h20);
    expect_issue(4'h4, 12'h001, 0, 0, 7'h41, 7'h21, 6'h21);
    expect_issue(4'h4, 12'h002, 1, 0, 7'h42, 7'h22, 6'h22);
    expect_issue(4'h4, 12'h004, 1, 0, 7'h44, 7'h24, 6'h24);
    expect_issue(4'h4, 12'h005, 1, 0, 7'h45, 7'h25, 6'h25);
    expect_issue(4'h4, 12'h006, 1, 0, 7'h46, 7'h26, 6'h26);
    expect_issue(4'h4, 12'h007, 1, 0, 7'h47, 7'h27, 6'h27);
    expect_issue(4'h5, 12'h050, 0, 0, 7'h50, 7'h30, 6'h30);
    step();
    wake(0, 5'h10); wake(1, 5'h10);
    step(); clear_wb();
    step(); wake(2, 5'h10);
    step(); clear_wb(); wake(0, 5'h11);
    step(); clear_wb(); wake(1, 5'h11);
    step(); clear_wb(); wake(2, 5'h11);
    step(); clear_wb(); wake(3, 5'h11); wake(0, 5'h14);
    step(); clear_wb();
    drain(4);

    // 5: x0 source never waits
    expect_issue(4'h6, 12'hABC, 0, 1, 7'h33, 7'h0A, 6'h05);
    enq(4'h6, 12'hABC, 7'h33, 0, 1, 7'h0A, 6'h05);
    @(negedge CLK); chk("t5_zero_issue", 32'(issue_valid), 1);
    drain(3);

    // 6: reset drops queued ops
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      enq(4'hA, 12'(i), 7'(i), 1, 0, 7'(i), 6'(i));
    @(negedge CLK); chk("t6_pre_reset_ready", 32'(iq_enq_ready), 1);
    step();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    issue_ready = 1'b1;
    @(negedge CLK);
    chk("t6_post_reset_issue", 32'(issue_valid), 0);
    chk("t6_post_reset_ready", 32'(iq_enq_ready), 1);
    repeat (5) step();
    chk("t6_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
